// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first, start/done handshake.
// Optional signed-overflow flag output ovf when SUB_SIGNED_OVF_EN is defined.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_r_sr;
  logic               r_brw;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
`ifdef SUB_SIGNED_OVF_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_ovf;
`endif

  logic w_d;
  logic w_brw_nxt;
  logic w_last;

  // Full-subtractor cell on the current LSBs
  assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_brw;
  assign w_brw_nxt = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_brw);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_r_sr  <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_brw   <= bin;
            r_r_sr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
`ifdef SUB_SIGNED_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
          end
        end
        S_SHIFT: begin
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_r_sr <= {w_d, r_r_sr[WIDTH-1:1]};
          r_brw  <= w_brw_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Publish on the final bit so diff/bout are valid while done is high
          if (w_last) begin
            r_diff  <= {w_d, r_r_sr[WIDTH-1:1]};
            r_bout  <= w_brw_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
`ifdef SUB_SIGNED_OVF_EN
            r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_diff;
  assign bout  = r_bout;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit and 4-bit instances, latency, handshake, reset abort.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start,  start4;
  logic [7:0] a, b;
  logic [3:0] a4, b4;
  logic       bin, bin4;
  logic       ready,  busy,  done,  bout;
  logic       ready4, busy4, done4, bout4;
  logic [7:0] diff;
  logic [3:0] diff4;
`ifdef SUB_SIGNED_OVF_EN
  logic       ovf, ovf4;
`endif

  int n_tests;
  int n_fail;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SUB_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SUB_SIGNED_OVF_EN
    , .ovf(ovf4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One 8-bit operation; operands are scrambled after acceptance to prove capture
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                       output int lat, output logic [7:0] d, output logic bo);
    @(negedge clk);
    a = ta; b = tbv; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ta ^ 8'h5A; b = ~tbv; bin = ~tbin;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d  = diff;
    bo = bout;
    @(negedge clk);
  endtask

  task automatic do_op4(input logic [3:0] ta, input logic [3:0] tbv, input logic tbin,
                        output int lat, output logic [3:0] d, output logic bo);
    @(negedge clk);
    a4 = ta; b4 = tbv; bin4 = tbin; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = ~ta; b4 = ~tbv; bin4 = ~tbin;
    lat = 1;
    while (done4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d  = diff4;
    bo = bout4;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ready, busy, done, bout} !== 4'b1000 || diff !== 8'h00) begin
      n_fail++;
      $display("FAIL reset8: ready=%b busy=%b done=%b diff=%h bout=%b, need 1 0 0 00 0",
               ready, busy, done, diff, bout);
    end
    n_tests++;
    if ({ready4, busy4, done4, bout4} !== 4'b1000 || diff4 !== 4'h0) begin
      n_fail++;
      $display("FAIL reset4: ready=%b busy=%b done=%b diff=%h bout=%b, need 1 0 0 0 0",
               ready4, busy4, done4, diff4, bout4);
    end
`ifdef SUB_SIGNED_OVF_EN
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b need 0", ovf);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF; bin = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n_tests++;
      if ({ready, busy, done} !== 3'b010 || diff !== 8'h00) begin
        n_fail++;
        $display("FAIL basic_shift k=%0d: ready=%b busy=%b done=%b diff=%h, need 0 1 0 00",
                 k, ready, busy, done, diff);
      end
      @(negedge clk);
    end
    n_tests++;
    if ({ready, busy, done} !== 3'b001 || diff !== 8'h02 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: ready=%b busy=%b done=%b diff=%h bout=%b, need 0 0 1 02 0",
               ready, busy, done, diff, bout);
    end
    @(negedge clk);
    n_tests++;
    if ({ready, busy, done} !== 3'b100 || diff !== 8'h02) begin
      n_fail++;
      $display("FAIL basic_idle: ready=%b busy=%b done=%b diff=%h, need 1 0 0 02",
               ready, busy, done, diff);
    end
  endtask

  task automatic test_borrow();
    logic [7:0] ta [4] = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
    logic [7:0] tv [4] = '{8'h01, 8'hFF, 8'h5A, 8'hA5};
    logic       ti [4] = '{1'b0,  1'b1,  1'b0,  1'b0};
    logic [7:0] ed [4] = '{8'hFF, 8'hFF, 8'h4B, 8'hB5};
    logic       eb [4] = '{1'b1,  1'b1,  1'b0,  1'b1};
    int lat; logic [7:0] d; logic bo;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tv[i], ti[i], lat, d, bo);
      n_tests++;
      if (lat != 9 || d !== ed[i] || bo !== eb[i]) begin
        n_fail++;
        $display("FAIL borrow%0d: lat=%0d diff=%h bout=%b, need 9 %h %b", i, lat, d, bo, ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done; int pos [3];
    n_done = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (n_done < 3) pos[n_done] = k;
        n_done++;
        n_tests++;
        if (diff !== 8'h0F || bout !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_diff k=%0d: diff=%h bout=%b, need 0f 0", k, diff, bout);
        end
      end
      if (k == 29) start = 1'b0;
    end
    n_tests++;
    if (n_done != 3 || pos[0] != 9 || pos[1] != 19 || pos[2] != 29) begin
      n_fail++;
      $display("FAIL b2b_spacing: count=%0d pos=%0d,%0d,%0d need 3 at 9,19,29",
               n_done, pos[0], pos[1], pos[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int n_done; int first;
    n_done = 0; first = -1;
    @(negedge clk);
    a = 8'h20; b = 8'h02; bin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first < 0) first = k;
        n_done++;
      end
      start = (k == 3 || k == 5 || k == 9);
      a = 8'hEE; b = 8'h11;
    end
    n_tests++;
    if (n_done != 1 || first != 9 || diff !== 8'h1E) begin
      n_fail++;
      $display("FAIL ignore_start: dones=%0d first=%0d diff=%h, need 1 at 9 diff 1e", n_done, first, diff);
    end
  endtask

  task automatic test_reset_mid();
    int n_done; int lat; logic [7:0] d; logic bo;
    n_done = 0;
    @(negedge clk);
    a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ready, busy, done, bout} !== 4'b1000 || diff !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b busy=%b done=%b diff=%h bout=%b, need 1 0 0 00 0",
               ready, busy, done, diff, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_tests++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: got %0d done pulses need 0", n_done);
    end
    do_op(8'h33, 8'h11, 1'b0, lat, d, bo);
    n_tests++;
    if (lat != 9 || d !== 8'h22 || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: lat=%0d diff=%h bout=%b, need 9 22 0", lat, d, bo);
    end
  endtask

  task automatic test_width4();
    int lat; logic [3:0] d; logic bo;
    do_op4(4'h3, 4'h5, 1'b0, lat, d, bo);
    n_tests++;
    if (lat != 5 || d !== 4'hE || bo !== 1'b1) begin
      n_fail++;
      $display("FAIL width4_a: lat=%0d diff=%h bout=%b, need 5 e 1", lat, d, bo);
    end
    do_op4(4'hF, 4'h0, 1'b1, lat, d, bo);
    n_tests++;
    if (lat != 5 || d !== 4'hE || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL width4_b: lat=%0d diff=%h bout=%b, need 5 e 0", lat, d, bo);
    end
  endtask

`ifdef SUB_SIGNED_OVF_EN
  task automatic test_ovf();
    int lat; logic [7:0] d; logic bo;
    do_op(8'h80, 8'h01, 1'b0, lat, d, bo);
    n_tests++;
    if (d !== 8'h7F || bo !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: diff=%h bout=%b ovf=%b, need 7f 0 1", d, bo, ovf);
    end
    do_op(8'h7F, 8'h01, 1'b0, lat, d, bo);
    n_tests++;
    if (d !== 8'h7E || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: diff=%h ovf=%b, need 7e 0", d, ovf);
    end
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b1; start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; bin = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_width4();
`ifdef SUB_SIGNED_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
